mem_wb_writeback: RTL and testbench

MEM_WB_WRITEBACK -- requirements
Module: mem_wb_writeback

---
 rtl/mem_wb_writeback_if.sv | 41 ++++
 rtl/mem_wb_writeback.sv | 79 +++++++
 tb/tb_mem_wb_writeback.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_wb_writeback_if.sv
// MEM->WB stage bundle: MEM-stage capture inputs, pipeline controls, decode bypass
// request and the register-file write / bypass / retire results.
interface mem_wb_writeback_if #(
    parameter int WIDTH = 32
);
    logic             memValid;
    logic             memRegWrite;
    logic [1:0]       memWbSel;
    logic [4:0]       memDest;
    logic [WIDTH-1:0] memAlu;
    logic [WIDTH-1:0] memLoad;
    logic [WIDTH-1:0] memPcPlus4;
    logic             stall;
    logic             flush;
    logic [4:0]       idReg1;
    logic [4:0]       idReg2;
    logic [WIDTH-1:0] idData1;
    logic [WIDTH-1:0] idData2;
    logic             writeEnable;
    logic [4:0]       writeReg;
    logic [WIDTH-1:0] writeData;
    logic [WIDTH-1:0] fwdData1;
    logic [WIDTH-1:0] fwdData2;
    logic             fwdHit1;
    logic             fwdHit2;
    logic [31:0]      retired;

    modport master (
        output memValid, memRegWrite, memWbSel, memDest, memAlu, memLoad, memPcPlus4,
        output stall, flush, idReg1, idReg2, idData1, idData2,
        input  writeEnable, writeReg, writeData, fwdData1, fwdData2, fwdHit1, fwdHit2,
        input  retired
    );

    modport slave (
        input  memValid, memRegWrite, memWbSel, memDest, memAlu, memLoad, memPcPlus4,
        input  stall, flush, idReg1, idReg2, idData1, idData2,
        output writeEnable, writeReg, writeData, fwdData1, fwdData2, fwdHit1, fwdHit2,
        output retired
    );
endinterface

// File: rtl/mem_wb_writeback.sv
// MEM/WB pipeline register with register-file write port, same-cycle decode
// bypass and a committed-instruction counter.
module mem_wb_writeback #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               resetN,
    mem_wb_writeback_if.slave  bus
);
    logic             r_wb_valid;
    logic             r_wb_reg_write;
    logic [4:0]       r_wb_dest;
    logic [WIDTH-1:0] r_wb_data;
    logic [31:0]      r_retired;

    logic [WIDTH-1:0] w_sel_data;
    logic             w_write_en;
    logic             w_hit1;
    logic             w_hit2;

    always_comb begin
        w_sel_data = '0;
        case (bus.memWbSel)
            2'b00:   w_sel_data = bus.memAlu;
            2'b01:   w_sel_data = bus.memLoad;
            2'b10:   w_sel_data = bus.memPcPlus4;
            default: w_sel_data = '0;
        endcase
    end

    // Flush beats stall; an invalid MEM slot is captured as a fully zeroed bubble.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_wb_valid     <= 1'b0;
            r_wb_reg_write <= 1'b0;
            r_wb_dest      <= 5'd0;
            r_wb_data      <= '0;
        end else if (bus.flush) begin
            r_wb_valid     <= 1'b0;
            r_wb_reg_write <= 1'b0;
            r_wb_dest      <= 5'd0;
            r_wb_data      <= '0;
        end else if (!bus.stall) begin
            if (bus.memValid) begin
                r_wb_valid     <= 1'b1;
                r_wb_reg_write <= bus.memRegWrite;
                r_wb_dest      <= bus.memDest;
                r_wb_data      <= w_sel_data;
            end else begin
                r_wb_valid     <= 1'b0;
                r_wb_reg_write <= 1'b0;
                r_wb_dest      <= 5'd0;
                r_wb_data      <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_retired <= 32'd0;
        end else if (r_wb_valid && !bus.stall && !bus.flush) begin
            r_retired <= r_retired + 32'd1;
        end
    end

    // Gating with stall makes the write land only on the edge that releases the stage.
    assign w_write_en = r_wb_valid && r_wb_reg_write && (r_wb_dest != 5'd0) && !bus.stall;
    assign w_hit1     = w_write_en && (bus.idReg1 == r_wb_dest);
    assign w_hit2     = w_write_en && (bus.idReg2 == r_wb_dest);

    assign bus.writeEnable = w_write_en;
    assign bus.writeReg    = r_wb_dest;
    assign bus.writeData   = r_wb_data;
    assign bus.fwdHit1     = w_hit1;
    assign bus.fwdHit2     = w_hit2;
    assign bus.fwdData1    = w_hit1 ? r_wb_data : bus.idData1;
    assign bus.fwdData2    = w_hit2 ? r_wb_data : bus.idData2;
    assign bus.retired     = r_retired;
endmodule

// File: tb/tb_mem_wb_writeback.sv
// Randomized bench for mem_wb_writeback: a stage/counter model built from the
// pipeline rules is checked every cycle, plus literal directed scenarios.
module tb_mem_wb_writeback;
    localparam int WIDTH = 32;

    logic clk;
    logic resetN;

    mem_wb_writeback_if #(.WIDTH(WIDTH)) bus();

    mem_wb_writeback #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    // Model: what instruction sits in WB and how many have committed.
    bit          m_valid;
    bit          m_rw;
    bit [4:0]    m_dest;
    bit [31:0]   m_data;
    bit [31:0]   m_retired;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_rw = 0; m_dest = 0; m_data = 0; m_retired = 0;
    endtask

    task automatic model_edge();
        bit [31:0] src;
        if (m_valid && !bus.stall && !bus.flush) m_retired = m_retired + 1;
        if (bus.flush) begin
            m_valid = 0; m_rw = 0; m_dest = 0; m_data = 0;
        end else if (!bus.stall) begin
            if (bus.memValid) begin
                src = (bus.memWbSel == 2'd0) ? bus.memAlu :
                      (bus.memWbSel == 2'd1) ? bus.memLoad :
                      (bus.memWbSel == 2'd2) ? bus.memPcPlus4 : 32'd0;
                m_valid = 1; m_rw = bus.memRegWrite; m_dest = bus.memDest; m_data = src;
            end else begin
                m_valid = 0; m_rw = 0; m_dest = 0; m_data = 0;
            end
        end
    endtask

    // Expected outputs derived from the model and the current decode request.
    task automatic check_outputs();
        bit        we;
        bit        h1;
        bit        h2;
        we = m_valid && m_rw && (m_dest != 0) && !bus.stall;
        h1 = we && (bus.idReg1 == m_dest);
        h2 = we && (bus.idReg2 == m_dest);
        cmp("writeEnable", {31'd0, bus.writeEnable}, {31'd0, we});
        cmp("writeReg",    {27'd0, bus.writeReg},    {27'd0, m_dest});
        cmp("writeData",   bus.writeData,            m_data);
        cmp("fwdHit1",     {31'd0, bus.fwdHit1},     {31'd0, h1});
        cmp("fwdHit2",     {31'd0, bus.fwdHit2},     {31'd0, h2});
        cmp("fwdData1",    bus.fwdData1,             h1 ? m_data : bus.idData1);
        cmp("fwdData2",    bus.fwdData2,             h2 ? m_data : bus.idData2);
        cmp("retired",     bus.retired,              m_retired);
    endtask

    // Called shortly after a rising edge: check at the falling edge, then advance one edge.
    task automatic cycle();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        if (resetN) model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        bus.memValid = 0; bus.memRegWrite = 0; bus.memWbSel = 0; bus.memDest = 0;
        bus.memAlu = 0; bus.memLoad = 0; bus.memPcPlus4 = 0;
        bus.stall = 0; bus.flush = 0;
        bus.idReg1 = 0; bus.idReg2 = 0; bus.idData1 = 0; bus.idData2 = 0;
    endtask

    task automatic issue(input bit rw, input bit [1:0] sel, input bit [4:0] dest,
                         input bit [31:0] alu, input bit [31:0] ld, input bit [31:0] pc4);
        bus.memValid = 1; bus.memRegWrite = rw; bus.memWbSel = sel; bus.memDest = dest;
        bus.memAlu = alu; bus.memLoad = ld; bus.memPcPlus4 = pc4;
    endtask

    task automatic async_reset_pulse();
        @(negedge clk);
        #2;
        resetN = 0;
        #1;
        model_reset();
        cmp("rst_writeEnable", {31'd0, bus.writeEnable}, 32'd0);
        cmp("rst_retired",     bus.retired,              32'd0);
        cmp("rst_writeReg",    {27'd0, bus.writeReg},    32'd0);
        cmp("rst_writeData",   bus.writeData,            32'd0);
        cmp("rst_fwdHit1",     {31'd0, bus.fwdHit1},     32'd0);
        cmp("rst_fwdHit2",     {31'd0, bus.fwdHit2},     32'd0);
        @(posedge clk);
        #3;
        resetN = 1;
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        idle_inputs();
        model_reset();
        resetN = 0;
        repeat (2) @(posedge clk);
        #1;
        cmp("reset_writeEnable", {31'd0, bus.writeEnable}, 32'd0);
        cmp("reset_retired",     bus.retired,              32'd0);
        resetN = 1;
        cycle();

        // ALU result to r8, then commit.
        issue(1, 2'b00, 5'd8, 32'h0000002A, 32'h11111111, 32'h22222222);
        cycle();
        idle_inputs();
        #1;
        cmp("alu_writeEnable", {31'd0, bus.writeEnable}, 32'd1);
        cmp("alu_writeReg",    {27'd0, bus.writeReg},    32'd8);
        cmp("alu_writeData",   bus.writeData,            32'h0000002A);
        cycle();
        cmp("alu_retired",     bus.retired,              32'd1);

        // Bypass hit on operand 1 only.
        issue(1, 2'b00, 5'd9, 32'h00001234, 32'h0, 32'h0);
        cycle();
        idle_inputs();
        bus.idReg1 = 5'd9;  bus.idData1 = 32'h0;
        bus.idReg2 = 5'd10; bus.idData2 = 32'hCAFE0010;
        #1;
        cmp("byp_fwdHit1",  {31'd0, bus.fwdHit1}, 32'd1);
        cmp("byp_fwdData1", bus.fwdData1,         32'h00001234);
        cmp("byp_fwdHit2",  {31'd0, bus.fwdHit2}, 32'd0);
        cmp("byp_fwdData2", bus.fwdData2,         32'hCAFE0010);
        cycle();

        // Load held by a 3-cycle stall writes once, retires once.
        issue(1, 2'b01, 5'd4, 32'h0, 32'hDEADBEEF, 32'h0);
        cycle();
        idle_inputs();
        bus.stall = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            cmp("ld_stall_we", {31'd0, bus.writeEnable}, 32'd0);
            cycle();
        end
        cmp("ld_stall_retired", bus.retired, 32'd2);
        bus.stall = 0;
        #1;
        cmp("ld_we",   {31'd0, bus.writeEnable}, 32'd1);
        cmp("ld_data", bus.writeData,            32'hDEADBEEF);
        cycle();
        cmp("ld_we_after", {31'd0, bus.writeEnable}, 32'd0);
        cmp("ld_retired",  bus.retired,              32'd3);

        // Writes to r0 are suppressed and never bypassed, but still retire.
        issue(1, 2'b00, 5'd0, 32'h0000FFFF, 32'h0, 32'h0);
        cycle();
        idle_inputs();
        bus.idReg1 = 5'd0; bus.idData1 = 32'h0;
        #1;
        cmp("r0_we",      {31'd0, bus.writeEnable}, 32'd0);
        cmp("r0_fwdHit1", {31'd0, bus.fwdHit1},     32'd0);
        cmp("r0_fwdData", bus.fwdData1,             32'h0);
        cycle();
        cmp("r0_retired", bus.retired, 32'd4);

        // Flush wins over stall; nothing retires.
        issue(1, 2'b10, 5'd31, 32'h0, 32'h0, 32'h00400004);
        cycle();
        idle_inputs();
        bus.stall = 1; bus.flush = 1;
        cycle();
        idle_inputs();
        #1;
        cmp("fl_we",      {31'd0, bus.writeEnable}, 32'd0);
        cmp("fl_retired", bus.retired,              32'd4);
        cycle();

        // Async reset mid-operation discards the held instruction.
        issue(1, 2'b00, 5'd5, 32'h00000055, 32'h0, 32'h0);
        cycle();
        idle_inputs();
        async_reset_pulse();
        cycle();
        cmp("rel_we",      {31'd0, bus.writeEnable}, 32'd0);
        cmp("rel_retired", bus.retired,              32'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            bus.memValid    = ($urandom_range(0, 3) != 0);
            bus.memRegWrite = ($urandom_range(0, 4) != 0);
            bus.memWbSel    = 2'($urandom_range(0, 3));
            bus.memDest     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            bus.memAlu      = $urandom;
            bus.memLoad     = $urandom;
            bus.memPcPlus4  = $urandom;
            bus.stall       = ($urandom_range(0, 4) == 0);
            bus.flush       = ($urandom_range(0, 9) == 0);
            bus.idReg1      = ($urandom_range(0, 1) == 0) ? m_dest : 5'($urandom);
            bus.idReg2      = ($urandom_range(0, 1) == 0) ? m_dest : 5'($urandom);
            bus.idData1     = $urandom;
            bus.idData2     = $urandom;
            if (n % 700 == 699) async_reset_pulse();
            else cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end
endmodule
